// File: rtl/guess_display_ctrl.sv
// Guess/history sequencer that feeds led_driver: edit cursor and colours, commit to a ring, review past guesses.
// Build option CLEAR_ON_SUBMIT_EN: when defined, the guess and cursor return to 1-1-1-1 / slot 0 after each commit.
module guess_display_ctrl #(
    parameter int HIST_DEPTH     = 8,
    parameter int COLOR_MAX      = 6,
    parameter int REVIEW_TIMEOUT = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic                            btn_color,
    input  logic                            btn_submit,
    input  logic                            btn_review,
    output logic                            blink_enable,
    output logic [1:0]                      blink_led,
    output logic [2:0]                      guess_rgb0,
    output logic [2:0]                      guess_rgb1,
    output logic [2:0]                      guess_rgb2,
    output logic [2:0]                      guess_rgb3,
    output logic [2:0]                      history_rgb0,
    output logic [2:0]                      history_rgb1,
    output logic [2:0]                      history_rgb2,
    output logic [2:0]                      history_rgb3,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count,
    output logic                            in_review
);

    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int TW = (REVIEW_TIMEOUT > 1) ? $clog2(REVIEW_TIMEOUT) : 1;

    typedef enum logic [1:0] {EDIT, COMMIT, REVIEW} state_t;
    typedef logic [3:0][2:0] guess_t;

    state_t        state, next_state;
    logic [1:0]    cursor;
    guess_t        slots;
    guess_t        ring [HIST_DEPTH];
    guess_t        hist_q, hist_d;
    logic [PW-1:0] wr_ptr, offset, offset_nxt;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic          blink_q, blink_d, review_q, review_d;

    // One-hot-by-priority decode: a higher-priority pulse swallows the others.
    logic do_submit, do_review, do_color, do_left, do_right, any_btn;
    assign do_submit = btn_submit;
    assign do_review = !btn_submit && btn_review;
    assign do_color  = !btn_submit && !btn_review && btn_color;
    assign do_left   = !btn_submit && !btn_review && !btn_color && btn_left && !btn_right;
    assign do_right  = !btn_submit && !btn_review && !btn_color && btn_right && !btn_left;
    assign any_btn   = btn_submit | btn_review | btn_color | btn_left | btn_right;

    // Ring slot holding the entry `off` steps older than the newest.
    function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] wp, input logic [PW-1:0] off);
        logic [PW:0] sum;
        sum = {1'b0, wp} + (PW+1)'(HIST_DEPTH - 1) - {1'b0, off};
        if (sum >= (PW+1)'(HIST_DEPTH))
            sum = sum - (PW+1)'(HIST_DEPTH);
        return sum[PW-1:0];
    endfunction

    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == 3'(COLOR_MAX)) ? 3'd1 : c + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EDIT;
        else        state <= next_state;
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        offset_nxt = '0;
        case (state)
            EDIT: begin
                if (do_submit)                      next_state = COMMIT;
                else if (do_review && count != '0)  next_state = REVIEW;
            end
            COMMIT: next_state = EDIT;
            REVIEW: begin
                offset_nxt = offset;
                if (do_submit || do_review)
                    next_state = EDIT;
                else if (!any_btn && timer == TW'(REVIEW_TIMEOUT - 1))
                    next_state = EDIT;
                else if (do_left && (CW'(offset) + CW'(1)) < count)
                    offset_nxt = offset + PW'(1);
                else if (do_right && offset != '0)
                    offset_nxt = offset - PW'(1);
                if (next_state != REVIEW)
                    offset_nxt = '0;
            end
            default: next_state = EDIT;
        endcase
    end

    // Output values are computed from the next state so they land in registers on the same edge.
    always_comb begin
        blink_d  = (next_state != REVIEW);
        review_d = (next_state == REVIEW);
        if (state == COMMIT)
            hist_d = slots;
        else if (count == '0)
            hist_d = '0;
        else
            hist_d = ring[ring_idx(wr_ptr, offset_nxt)];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor <= '0;
            slots  <= {4{3'd1}};
            wr_ptr <= '0;
            count  <= '0;
            offset <= '0;
            timer  <= '0;
        end else begin
            offset <= offset_nxt;
            timer  <= '0;
            case (state)
                EDIT: begin
                    if (do_color)      slots[cursor] <= next_color(slots[cursor]);
                    else if (do_left)  cursor <= cursor - 2'd1;
                    else if (do_right) cursor <= cursor + 2'd1;
                end
                COMMIT: begin
                    wr_ptr <= (wr_ptr == PW'(HIST_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                    if (count != CW'(HIST_DEPTH))
                        count <= count + CW'(1);
`ifdef CLEAR_ON_SUBMIT_EN
                    slots  <= {4{3'd1}};
                    cursor <= '0;
`endif
                end
                REVIEW: begin
                    if (!any_btn && next_state == REVIEW)
                        timer <= timer + TW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the history storage has no reset; stale entries are hidden by count.
    always_ff @(posedge clk) begin
        if (rst_n && state == COMMIT)
            ring[wr_ptr] <= slots;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q  <= 1'b0;
            review_q <= 1'b0;
            hist_q   <= '0;
        end else begin
            blink_q  <= blink_d;
            review_q <= review_d;
            hist_q   <= hist_d;
        end
    end

    assign blink_enable = blink_q;
    assign in_review    = review_q;
    assign blink_led    = cursor;
    assign hist_count   = count;
    assign guess_rgb0   = slots[0];
    assign guess_rgb1   = slots[1];
    assign guess_rgb2   = slots[2];
    assign guess_rgb3   = slots[3];
    assign history_rgb0 = hist_q[0];
    assign history_rgb1 = hist_q[1];
    assign history_rgb2 = hist_q[2];
    assign history_rgb3 = hist_q[3];

endmodule

// File: tb/tb_guess_display_ctrl.sv
// Self-checking bench for guess_display_ctrl: directed scenarios plus random pulses against a queue-based model.
// Honours CLEAR_ON_SUBMIT_EN the same way the design does.
module tb_guess_display_ctrl;

    localparam int HD   = 8;
    localparam int CMAX = 6;
    localparam int TO   = 1000;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_SUB  = 5'b10000;
    localparam logic [4:0] B_REV  = 5'b01000;
    localparam logic [4:0] B_COL  = 5'b00100;
    localparam logic [4:0] B_L    = 5'b00010;
    localparam logic [4:0] B_R    = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0, btn_submit = 1'b0, btn_review = 1'b0;
    logic blink_enable, in_review;
    logic [1:0] blink_led;
    logic [2:0] guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0] history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic [$clog2(HD+1)-1:0] hist_count;

    guess_display_ctrl #(.HIST_DEPTH(HD), .COLOR_MAX(CMAX), .REVIEW_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
        .btn_submit(btn_submit), .btn_review(btn_review),
        .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1), .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
        .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
        .hist_count(hist_count), .in_review(in_review)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: mode 0 = edit, 1 = commit, 2 = review; history is a queue, newest at the back.
    logic [2:0]  m_guess [4];
    int          m_cur, m_mode, m_off, m_idle;
    bit          m_in_rst;
    logic [11:0] m_hist [$];

    function automatic logic [11:0] m_pack();
        return {m_guess[3], m_guess[2], m_guess[1], m_guess[0]};
    endfunction

    function automatic logic [11:0] m_shown();
        int n;
        n = m_hist.size();
        if (n == 0) return '0;
        return m_hist[n - 1 - ((m_mode == 2) ? m_off : 0)];
    endfunction

    task automatic model_step(input logic [4:0] b, input logic rst);
        int g;
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_guess[i] = 3'd1;
            m_cur = 0; m_mode = 0; m_off = 0; m_idle = 0; m_in_rst = 1'b1;
            m_hist.delete();
            return;
        end
        m_in_rst = 1'b0;
        case (m_mode)
            0: begin
                if (b[4]) m_mode = 1;
                else if (b[3]) begin
                    if (m_hist.size() > 0) begin m_mode = 2; m_off = 0; m_idle = 0; end
                end else if (b[2]) begin
                    g = int'(m_guess[m_cur]);
                    m_guess[m_cur] = 3'((g % CMAX) + 1);
                end else if (b[1] != b[0]) begin
                    m_cur = b[1] ? (m_cur + 3) % 4 : (m_cur + 1) % 4;
                end
            end
            1: begin
                m_hist.push_back(m_pack());
                if (m_hist.size() > HD) void'(m_hist.pop_front());
`ifdef CLEAR_ON_SUBMIT_EN
                for (int i = 0; i < 4; i++) m_guess[i] = 3'd1;
                m_cur = 0;
`endif
                m_mode = 0;
            end
            default: begin
                if (b[4] || b[3]) m_mode = 0;
                else if (b != 5'b0) begin
                    m_idle = 0;
                    if (!b[2] && b[1] != b[0]) begin
                        if (b[1] && m_off < m_hist.size() - 1) m_off++;
                        else if (b[0] && m_off > 0) m_off--;
                    end
                end else if (m_idle == TO - 1) m_mode = 0;
                else m_idle++;
            end
        endcase
    endtask

    task automatic compare_all();
        check("guess", 32'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), 32'(m_pack()));
        check("blink_led", 32'(blink_led), 32'(m_cur));
        check("blink_enable", 32'(blink_enable), 32'(!m_in_rst && m_mode != 2));
        check("in_review", 32'(in_review), 32'(!m_in_rst && m_mode == 2));
        check("hist_count", 32'(hist_count), 32'(m_hist.size()));
        check("history", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(m_shown()));
    endtask

    task automatic tick(input logic [4:0] b);
        {btn_submit, btn_review, btn_color, btn_left, btn_right} = b;
        @(posedge clk);
        model_step(b, rst_n);
        #1;
        compare_all();
        {btn_submit, btn_review, btn_color, btn_left, btn_right} = 5'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick(B_NONE);
        rst_n = 1'b1;
    endtask

    // Drives the guess to target (slot s in bits 3s+2:3s) using cursor moves and colour presses.
    task automatic set_guess(input logic [11:0] target);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4 && m_cur != s; k++) tick(B_R);
            for (int n = 0; n < CMAX && m_guess[s] != target[3*s +: 3]; n++) tick(B_COL);
        end
    endtask

    logic [11:0] g_tab [9];
    logic [11:0] target;
    int r;

    initial begin
        // Reset and release
        do_reset(3);
        check("rst_blink_en", 32'(blink_enable), 32'd0);
        check("rst_guess", 32'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), 32'h249);
        tick(B_NONE);
        check("rel_blink_en", 32'(blink_enable), 32'd1);

        // Cursor and colour wrap
        tick(B_L);
        check("left_wrap", 32'(blink_led), 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick(B_COL);
            check("color_wrap", 32'(guess_rgb3), 32'((i + 1) % 6 + 1));
        end
        tick(B_L | B_R);
        check("left_right_hold", 32'(blink_led), 32'd3);

        // Review with no history is ignored
        tick(B_REV);
        check("empty_review", 32'(in_review), 32'd0);
        check("empty_review_blink", 32'(blink_enable), 32'd1);

        // Commit, with submit overriding a simultaneous colour press
        target = {3'd5, 3'd4, 3'd3, 3'd2};
        set_guess(target);
        tick(B_SUB | B_COL);
        check("submit_color_guess", 32'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), 32'(target));
        tick(B_NONE);
        check("commit_history", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(target));
        check("commit_count", 32'(hist_count), 32'd1);
`ifdef CLEAR_ON_SUBMIT_EN
        check("commit_guess_cleared", 32'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), 32'h249);
`else
        check("commit_guess_kept", 32'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), 32'(target));
`endif

        // Fill past capacity, then walk to the oldest entry
        do_reset(1);
        for (int k = 0; k < 9; k++) begin
            g_tab[k] = {3'd1, 3'd1, 3'(1 + k / 6), 3'(1 + k % 6)};
            set_guess(g_tab[k]);
            tick(B_SUB);
            tick(B_NONE);
        end
        check("full_count", 32'(hist_count), 32'd8);
        tick(B_REV);
        check("review_newest", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(g_tab[8]));
        repeat (7) tick(B_L);
        check("review_oldest", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(g_tab[1]));
        tick(B_L);
        check("review_oldest_sat", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(g_tab[1]));

        // Idle timeout back to edit
        repeat (TO - 1) tick(B_NONE);
        check("timeout_not_yet", 32'(in_review), 32'd1);
        tick(B_NONE);
        check("timeout_exit", 32'(in_review), 32'd0);
        check("timeout_blink", 32'(blink_enable), 32'd1);
        check("timeout_newest", 32'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 32'(g_tab[8]));

        // Random pulses, with occasional mid-flight resets
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 50) tick(B_NONE);
            else if (r < 60) tick(B_L);
            else if (r < 70) tick(B_R);
            else if (r < 76) tick(B_COL);
            else if (r < 82) tick(B_SUB);
            else if (r < 90) tick(B_REV);
            else if (r < 93) tick(B_L | B_R);
            else if (r < 96) tick(B_SUB | B_COL);
            else if (r < 99) tick(B_REV | B_L);
            else             do_reset(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
